mapper_bus_master: RTL and testbench
====================================

MAPPER_BUS_MASTER -- requirements
Module: mapper_bus_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ce, input, 1, M2 CPU-cycle enable; mapper registers sample on clk edges where ce=1.
REQ-005 SHALL have port bus_grant, input, 1, CPU bus free for this master.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in 16, cmd_wdata in 8; together these form the command push.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 8, rsp_open out 1; together these form the read/write completion.
REQ-008 SHALL have ports prg_ain out 16, prg_read out 1, prg_write out 1, prg_din out 8; these drive the mapper CPU side.
REQ-009 SHALL have ports prg_dout in 8 and prg_bus_write in 1; these are mapper read data and its valid flag.
REQ-010 SHALL have port busy, output, 1; it is high when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-011 SHALL accept a command on the clk edge where cmd_valid and cmd_ready are both 1; cmd_ready = FIFO not full.
REQ-012 SHALL permit push and pop in the same cycle; the occupancy count SHALL stay unchanged and the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 SHALL use FSM states IDLE, ADDR, ACCESS, RESP.
REQ-014 IDLE -> ADDR when the FIFO is non-empty and bus_grant=1; this pops the head into the working register.
REQ-015 ADDR: prg_ain=addr and prg_din=wdata; prg_read and prg_write are 0; the FSM waits for the first ce=1 cycle, then goes to ACCESS.
REQ-016 ACCESS: prg_write=cmd_write and prg_read=!cmd_write; the FSM waits for the next ce=1 cycle.
REQ-017 On that ACCESS ce cycle the block SHALL capture rsp_rdata=prg_dout and rsp_open=!prg_bus_write, then go to RESP.
REQ-018 For writes, rsp_rdata=0 and rsp_open=0.
REQ-019 Exactly one ce=1 cycle SHALL see prg_write or prg_read high per command; no double strobe is allowed.
REQ-020 RESP: rsp_valid=1 and outputs are stable until rsp_ready=1; on that edge the FSM goes to IDLE.
REQ-021 The FIFO SHALL continue accepting commands during RESP.
REQ-022 Outside ADDR and ACCESS, prg_ain=0, prg_din=0, prg_read=0 and prg_write=0.
REQ-023 bus_grant deasserting in ADDR or ACCESS SHALL NOT abort; the access completes.
REQ-024 bus_grant is checked only at IDLE.
REQ-025 Minimum command-to-rsp_valid latency SHALL be 1 clk (pop) + 2 ce pulses + 1 clk.
REQ-026 Commands SHALL complete strictly in FIFO order.

Reset
REQ-027 reset SHALL force: state=IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_open=0, prg_*=0, busy=0.
REQ-028 reset mid-ADDR or mid-ACCESS SHALL drop strobes on the same edge; queued commands SHALL be discarded with no response.
REQ-029 reset SHALL take priority over a simultaneous push or ce.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the command struct {write, addr[15:0], wdata[7:0]}.
REQ-031 The FIFO SHALL be one sub-module, mapper_cmd_fifo, with parameter FIFO_DEPTH, push/pop/full/empty, and registered storage.
REQ-032 The FSM, working register and response registers SHALL reside in mapper_bus_master.

Verification
REQ-033 ce every 3rd clk; write 0x8000<=0x05 -> exactly one ce cycle with prg_write=1, prg_ain=0x8000, prg_din=0x05; then rsp_valid, rsp_open=0.
REQ-034 Read 0x5800 with prg_dout=0x2A and prg_bus_write=1 -> rsp_rdata=0x2A, rsp_open=0; read 0x8000 with prg_bus_write=0 -> rsp_open=1.
REQ-035 Push 5 commands back-to-back with FIFO_DEPTH=4 and rsp_ready=0 -> cmd_ready falls after the 4th accepted push (one more accepted when the first pops); order preserved.
REQ-036 bus_grant=0 with the FIFO holding 2 commands -> no prg strobe and busy=1; raise grant -> both complete in order.
REQ-037 Assert reset during ACCESS -> prg_write=0 on the next edge, no rsp_valid, FIFO empty, busy=0.
REQ-038 Drop bus_grant during ADDR -> the access still completes with one strobe and a correct response.

Source files
------------

// File: rtl/mapper_bus_master_pkg.sv
// Shared types for the mapper bus master: FSM state encoding and the queued command record.
package mapper_bus_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef struct packed {
      logic        write;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } cmd_t;

endpackage

// File: rtl/mapper_cmd_fifo.sv
// Command FIFO for the mapper bus master; power-of-two depth so pointers wrap naturally.
module mapper_cmd_fifo
   import mapper_bus_master_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  cmd_t push_data,
   input  logic pop,
   output cmd_t pop_data,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   cmd_t           mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           do_push;
   logic           do_pop;

   assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
   assign empty    = (count_reg == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         // Simultaneous push and pop leaves occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/mapper_bus_master.sv
// Drives queued CPU-side accesses into a mapper, one strobe per M2 cycle enable, and returns completions.
module mapper_bus_master
   import mapper_bus_master_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        bus_grant,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_open,
   output logic [15:0] prg_ain,
   output logic        prg_read,
   output logic        prg_write,
   output logic [7:0]  prg_din,
   input  logic [7:0]  prg_dout,
   input  logic        prg_bus_write,
   output logic        busy
);

   state_t state_reg;
   cmd_t   work_reg;
   cmd_t   push_cmd;
   cmd_t   fifo_head;
   logic   fifo_full;
   logic   fifo_empty;
   logic   fifo_pop;

   assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
   assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty && bus_grant;
   assign cmd_ready = !fifo_full;
   assign busy      = !fifo_empty || (state_reg != ST_IDLE);

   mapper_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cmd_valid),
      .push_data (push_cmd),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         work_reg  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'h00;
         rsp_open  <= 1'b0;
         prg_ain   <= 16'h0000;
         prg_din   <= 8'h00;
         prg_read  <= 1'b0;
         prg_write <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (fifo_pop) begin
                  work_reg  <= fifo_head;
                  prg_ain   <= fifo_head.addr;
                  prg_din   <= fifo_head.wdata;
                  state_reg <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               // Strobe rises after this ce so the mapper first samples it on the following ce.
               if (ce) begin
                  prg_write <= work_reg.write;
                  prg_read  <= !work_reg.write;
                  state_reg <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (ce) begin
                  rsp_rdata <= work_reg.write ? 8'h00 : prg_dout;
                  rsp_open  <= work_reg.write ? 1'b0 : !prg_bus_write;
                  rsp_valid <= 1'b1;
                  prg_ain   <= 16'h0000;
                  prg_din   <= 8'h00;
                  prg_read  <= 1'b0;
                  prg_write <= 1'b0;
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mapper_bus_master.sv
// Directed bench for mapper_bus_master: vector table plus FIFO-full, grant, reset and grant-drop sequences.
module tb_mapper_bus_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b0;
   logic        bus_grant = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [15:0] cmd_addr = 16'h0;
   logic [7:0]  cmd_wdata = 8'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_rdata;
   logic        rsp_open;
   logic [15:0] prg_ain;
   logic        prg_read;
   logic        prg_write;
   logic [7:0]  prg_din;
   logic [7:0]  prg_dout;
   logic        prg_bus_write = 1'b1;
   logic        busy;

   logic        dout_follow = 1'b0;
   logic [7:0]  dout_fixed = 8'h00;

   int n_vec  = 0;
   int n_miss = 0;

   int          strobe_cnt = 0;
   logic [15:0] last_ain;
   logic [7:0]  last_din;
   logic        last_wr;
   logic [15:0] strobe_q [$];

   mapper_bus_master #(.FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .ce            (ce),
      .bus_grant     (bus_grant),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_open      (rsp_open),
      .prg_ain       (prg_ain),
      .prg_read      (prg_read),
      .prg_write     (prg_write),
      .prg_din       (prg_din),
      .prg_dout      (prg_dout),
      .prg_bus_write (prg_bus_write),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // ce high for one clk out of every three, changed just after the rising edge.
   int ce_cnt = 0;
   always @(posedge clk) begin
      #2;
      if (ce_cnt == 2) begin
         ce_cnt = 0;
         ce = 1'b1;
      end else begin
         ce_cnt = ce_cnt + 1;
         ce = 1'b0;
      end
   end

   // Mapper read data model: either a fixed byte or a function of the address.
   always_comb prg_dout = dout_follow ? (prg_ain[7:0] ^ 8'h5A) : dout_fixed;

   // Count strobes as the mapper would see them (strobe high on a ce cycle).
   always @(negedge clk) begin
      if (!reset && ce && (prg_read || prg_write)) begin
         strobe_cnt = strobe_cnt + 1;
         last_ain   = prg_ain;
         last_din   = prg_din;
         last_wr    = prg_write;
         strobe_q.push_back(prg_ain);
      end
   end

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  dout;
      logic        bw;
      logic [7:0]  exp_rdata;
      logic        exp_open;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic wr, input logic [15:0] a, input logic [7:0] d);
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) check("push_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [7:0] d, output logic o);
      int t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("idle_prg_ain", {16'd0, prg_ain}, 32'd0);
      d = rsp_rdata;
      o = rsp_open;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      logic [7:0]  rd;
      logic        op;
      int          s0;
      int          t;
      logic [15:0] exp_a;

      vecs[0] = '{1'b1, 16'h8000, 8'h05, 8'hEE, 1'b1, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 16'h5800, 8'h00, 8'h2A, 1'b1, 8'h2A, 1'b0};
      vecs[2] = '{1'b0, 16'h8000, 8'h00, 8'h77, 1'b0, 8'h77, 1'b1};
      vecs[3] = '{1'b1, 16'h6000, 8'hFF, 8'h33, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{1'b0, 16'hFFFF, 8'h12, 8'h00, 1'b1, 8'h00, 1'b0};
      vecs[5] = '{1'b0, 16'h0001, 8'h00, 8'h80, 1'b1, 8'h80, 1'b0};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_strobes", {30'd0, prg_read, prg_write}, 32'd0);
      check("rst_prg_ain", {16'd0, prg_ain}, 32'd0);
      check("rst_rsp", {23'd0, rsp_open, rsp_rdata}, 32'd0);

      // Table-driven single transactions.
      for (int i = 0; i < 6; i++) begin
         dout_follow   = 1'b0;
         dout_fixed    = vecs[i].dout;
         prg_bus_write = vecs[i].bw;
         s0 = strobe_cnt;
         push(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         get_rsp(rd, op);
         check("vec_strobes", strobe_cnt - s0, 32'd1);
         check("vec_ain", {16'd0, last_ain}, {16'd0, vecs[i].addr});
         check("vec_din", {24'd0, last_din}, {24'd0, vecs[i].wdata});
         check("vec_wr", {31'd0, last_wr}, {31'd0, vecs[i].wr});
         check("vec_rdata", {24'd0, rd}, {24'd0, vecs[i].exp_rdata});
         check("vec_open", {31'd0, op}, {31'd0, vecs[i].exp_open});
         $display("vec %0d: wr=%0d addr=%04h rdata=%02h open=%0d", i, vecs[i].wr, vecs[i].addr, rd, op);
      end

      // FIFO fill: four queued with no grant, fifth enters once the head pops.
      dout_follow   = 1'b1;
      prg_bus_write = 1'b1;
      bus_grant     = 1'b0;
      strobe_q.delete();
      s0 = strobe_cnt;
      for (int i = 1; i <= 4; i++) push(1'b0, 16'h4100 + 16'(i), 8'h00);
      @(negedge clk);
      check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("full_busy", {31'd0, busy}, 32'd1);
      bus_grant = 1'b1;
      push(1'b0, 16'h4105, 8'h00);
      @(negedge clk);
      check("refill_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         exp_a = 16'h4100 + 16'(i);
         get_rsp(rd, op);
         check("order_rdata", {24'd0, rd}, {24'd0, exp_a[7:0] ^ 8'h5A});
         $display("fill rsp %0d: rdata=%02h open=%0d", i, rd, op);
      end
      check("fill_strobes", strobe_cnt - s0, 32'd5);
      for (int i = 1; i <= 5; i++) begin
         exp_a = 16'h4100 + 16'(i);
         if (strobe_q.size() > 0) check("order_ain", {16'd0, strobe_q.pop_front()}, {16'd0, exp_a});
         else check("order_ain_missing", strobe_q.size(), 32'd1);
      end

      // No grant: commands wait, busy stays high.
      bus_grant = 1'b0;
      push(1'b0, 16'h4201, 8'h00);
      push(1'b0, 16'h4202, 8'h00);
      s0 = strobe_cnt;
      repeat (20) @(negedge clk);
      check("nogrant_strobes", strobe_cnt - s0, 32'd0);
      check("nogrant_busy", {31'd0, busy}, 32'd1);
      check("nogrant_rsp", {31'd0, rsp_valid}, 32'd0);
      bus_grant = 1'b1;
      get_rsp(rd, op);
      check("grant_rdata0", {24'd0, rd}, {24'd0, 8'h01 ^ 8'h5A});
      get_rsp(rd, op);
      check("grant_rdata1", {24'd0, rd}, {24'd0, 8'h02 ^ 8'h5A});
      check("grant_strobes", strobe_cnt - s0, 32'd2);
      $display("grant sequence: last rdata=%02h", rd);

      // Reset while the write strobe is high; the queued second write is discarded.
      push(1'b1, 16'h8000, 8'h11);
      push(1'b1, 16'h8001, 8'h22);
      t = 0;
      @(negedge clk);
      while (!prg_write && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("rst_mid_seen", {31'd0, prg_write}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_write", {31'd0, prg_write}, 32'd0);
      check("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      s0 = strobe_cnt;
      repeat (20) @(negedge clk);
      check("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
      check("post_rst_strobes", strobe_cnt - s0, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      $display("reset during access: busy=%0d rsp_valid=%0d", busy, rsp_valid);

      // Grant dropped while in ADDR: access still finishes.
      dout_follow   = 1'b0;
      dout_fixed    = 8'h3C;
      prg_bus_write = 1'b0;
      s0 = strobe_cnt;
      push(1'b0, 16'h5801, 8'h00);
      t = 0;
      @(negedge clk);
      while (!(prg_ain == 16'h5801 && !prg_read) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("addr_phase_seen", {16'd0, prg_ain}, 32'h5801);
      bus_grant = 1'b0;
      get_rsp(rd, op);
      check("drop_rdata", {24'd0, rd}, 32'h3C);
      check("drop_open", {31'd0, op}, 32'd1);
      check("drop_strobes", strobe_cnt - s0, 32'd1);
      $display("grant drop: rdata=%02h open=%0d", rd, op);
      bus_grant = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
